crp_response_reader: RTL

Reader-side sequencer for the challenge/response path of the multi-PUF design. It accepts a challenge request and drives it onto the obfuscated-challenge stage. It then re-arms the PUF cells and samples the PUF response bit NSAMP times, and majority-votes the samples. The voted response, its challenge and a stability flag are delivered on a valid/ready interface to the downstream CRP logger or authentication logic.

---
 rtl/crp_response_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/crp_response_reader.sv
// Reader-side sequencer for the PUF challenge/response path: arms, settles,
// samples and majority-votes the PUF response, then hands it off downstream.
module crp_response_reader #(
    parameter int CW      = 3,
    parameter int ARM_CYC = 2,
    parameter int SETTLE  = 8,
    parameter int NSAMP   = 7
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       start,
    input  logic [CW-1:0]              C_in,
    output logic                       busy,
    output logic [CW-1:0]              puf_C,
    output logic                       puf_arm,
    input  logic                       puf_resp,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp,
    output logic [CW-1:0]              resp_C,
    output logic                       resp_stable,
    output logic [$clog2(NSAMP+1)-1:0] ones
);

    localparam int OW   = $clog2(NSAMP + 1);
    localparam int TMAX = (ARM_CYC > SETTLE) ? ARM_CYC : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t        state_q;
    logic [TW-1:0] tmr_q;
    logic [OW-1:0] smp_q;
    logic [OW-1:0] ones_q;
    logic [CW-1:0] puf_C_q;
    logic [CW-1:0] resp_C_q;
    logic          busy_q;
    logic          arm_q;
    logic          valid_q;
    logic          resp_q;
    logic          stable_q;
    logic          sync1_q;
    logic          sync2_q;

    logic [OW-1:0] ones_d;
    logic [OW-1:0] smp_d;

    // Count including the sample taken on the closing SAMPLE edge
    assign ones_d = ones_q + OW'(sync2_q);
    assign smp_d  = smp_q + OW'(1);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            smp_q    <= '0;
            ones_q   <= '0;
            puf_C_q  <= '0;
            resp_C_q <= '0;
            busy_q   <= 1'b0;
            arm_q    <= 1'b0;
            valid_q  <= 1'b0;
            resp_q   <= 1'b0;
            stable_q <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
        end else begin
            sync1_q <= puf_resp;
            sync2_q <= sync1_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_ARM;
                        puf_C_q  <= C_in;
                        resp_C_q <= C_in;
                        ones_q   <= '0;
                        smp_q    <= '0;
                        busy_q   <= 1'b1;
                        arm_q    <= 1'b1;
                        tmr_q    <= TW'(ARM_CYC - 1);
                    end
                end
                ST_ARM: begin
                    if (tmr_q == '0) begin
                        state_q <= ST_SETTLE;
                        arm_q   <= 1'b0;
                        tmr_q   <= TW'(SETTLE - 1);
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (tmr_q == '0) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                ST_SAMPLE: begin
                    ones_q <= ones_d;
                    smp_q  <= smp_d;
                    if (smp_d == OW'(NSAMP)) begin
                        state_q  <= ST_DONE;
                        valid_q  <= 1'b1;
                        resp_q   <= (ones_d > OW'(NSAMP / 2));
                        stable_q <= (ones_d == '0) || (ones_d == OW'(NSAMP));
                    end else begin
                        state_q <= ST_ARM;
                        arm_q   <= 1'b1;
                        tmr_q   <= TW'(ARM_CYC - 1);
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign puf_C       = puf_C_q;
    assign puf_arm     = arm_q;
    assign resp_valid  = valid_q;
    assign resp        = resp_q;
    assign resp_C      = resp_C_q;
    assign resp_stable = stable_q;
    assign ones        = ones_q;

endmodule
